// File: rtl/clock_gate_divider_ctrl.sv
// Enable sequencer for a ClockGater: one gated source pulse every divActive cycles.
// Optional pulse counter behind CLOCK_DIV_PULSE_COUNT_EN.
module clock_gate_divider_ctrl #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 divReq_valid,
  input  logic [DIV_WIDTH-1:0] divReq_bits,
  output logic                 divReq_ready,
  output logic                 gateEnable,
  output logic [DIV_WIDTH-1:0] divActive,
  output logic                 updateDone,
  output logic                 running,
  output logic [31:0]          pulseCount
);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  typedef enum logic [1:0] {STOPPED, RUNNING, STOPPING} state_t;

  state_t               state, state_d;
  logic [DIV_WIDTH-1:0] cnt, cnt_d, div_d, pend_div, pend_div_d;
  logic                 pending, pending_d, gate_d, done_d;
  logic                 boundary, accept;

  assign boundary = (cnt == divActive - ONE);
  assign accept   = divReq_valid && divReq_ready;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    div_d      = divActive;
    pend_div_d = pend_div;
    pending_d  = pending;
    done_d     = 1'b0;
    gate_d     = 1'b0;
    unique case (state)
      STOPPED: begin
        // idle: a pending ratio lands immediately, before any restart uses it
        if (pending) begin
          div_d     = pend_div;
          pending_d = 1'b0;
          done_d    = 1'b1;
        end
        if (run) begin
          state_d = RUNNING;
          cnt_d   = div_d - ONE;
        end
      end
      RUNNING, STOPPING: begin
        cnt_d = boundary ? '0 : cnt + ONE;
        if (boundary && pending) begin
          div_d     = pend_div;
          pending_d = 1'b0;
          done_d    = 1'b1;
        end
        if (run)
          state_d = RUNNING;
        else if (state == STOPPING && boundary)
          state_d = STOPPED;
        else
          state_d = STOPPING;
        // next cnt is 0 and we stay/return to RUNNING
        gate_d = run && boundary;
      end
      default: state_d = STOPPED;
    endcase
    // accept never coincides with apply: ready implies nothing is pending
    if (accept && divReq_bits != '0) begin
      pend_div_d = divReq_bits;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= STOPPED;
      cnt          <= '0;
      gateEnable   <= 1'b0;
      divActive    <= DIV_RST;
      pend_div     <= '0;
      pending      <= 1'b0;
      divReq_ready <= 1'b1;
      updateDone   <= 1'b0;
      running      <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      gateEnable   <= gate_d;
      divActive    <= div_d;
      pend_div     <= pend_div_d;
      pending      <= pending_d;
      divReq_ready <= ~pending_d;
      updateDone   <= done_d;
      running      <= (state_d != STOPPED);
    end
  end

`ifdef CLOCK_DIV_PULSE_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pulseCount <= '0;
    else if (gateEnable)
      pulseCount <= pulseCount + 32'd1;
  end
`else
  assign pulseCount = '0;
`endif

endmodule
